// File: rtl/dram_bus_master.sv
// Request/response master for the asynchronous-SRAM-style DRAM bus.
// Handles single beats and incrementing bursts with programmable wait states.
module dram_bus_master #(
  parameter int DWIDTH      = 8,
  parameter int AWIDTH      = 4,
  parameter int LWIDTH      = 2,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              i_ck,
  input  logic              i_rstn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_rw,
  input  logic [AWIDTH-1:0] i_req_addr,
  input  logic [LWIDTH-1:0] i_req_len,
  input  logic              i_wdata_valid,
  output logic              o_wdata_ready,
  input  logic [DWIDTH-1:0] i_wdata,
  output logic              o_rsp_valid,
  output logic [DWIDTH-1:0] o_rsp_data,
  output logic              o_rsp_last,
  output logic              o_busy,
  output logic              o_csn,
  output logic              o_rw,
  output logic [AWIDTH-1:0] o_address,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_data_oe,
  input  logic [DWIDTH-1:0] i_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WLOAD  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam int                CWIDTH   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CWIDTH-1:0] CNT_LAST = CWIDTH'(WAIT_CYCLES);

  logic [1:0]        state;
  logic              alive_q;   // low only until the first edge after reset release
  logic              rw_q;
  logic [AWIDTH-1:0] addr_q;
  logic [LWIDTH-1:0] left_q;
  logic [DWIDTH-1:0] data_q;
  logic [CWIDTH-1:0] cnt_q;
  logic              req_fire;
  logic              in_access;

  assign in_access = (state == ACCESS);
  assign req_fire  = i_req_valid && o_req_ready;

  // Bus outputs are decoded from registered state only, so no input can glitch the pins.
  assign o_req_ready   = alive_q && (state == IDLE);
  assign o_wdata_ready = (state == WLOAD);
  assign o_busy        = (state != IDLE);
  assign o_csn         = !in_access;
  assign o_rw          = in_access ? rw_q : 1'b1;
  assign o_address     = addr_q;
  assign o_data        = data_q;
  assign o_data_oe     = in_access && !rw_q;

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values; the async reset branch covers every register.
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      alive_q     <= 1'b0;
      rw_q        <= 1'b1;
      addr_q      <= '0;
      left_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_last  <= 1'b0;
    end else begin
      alive_q     <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            rw_q   <= i_req_rw;
            addr_q <= i_req_addr;
            left_q <= i_req_len;
            cnt_q  <= '0;
            state  <= i_req_rw ? ACCESS : WLOAD;
          end
        end
        WLOAD: begin
          if (i_wdata_valid) begin
            data_q <= i_wdata;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CWIDTH'(1);
          end else begin
            cnt_q <= '0;
            if (rw_q) begin
              o_rsp_valid <= 1'b1;
              o_rsp_data  <= i_data;
              o_rsp_last  <= (left_q == '0);
            end
            if (left_q != '0) begin
              // Address wraps naturally at the top of the AWIDTH range.
              left_q <= left_q - LWIDTH'(1);
              addr_q <= addr_q + AWIDTH'(1);
              state  <= rw_q ? ACCESS : WLOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_bus_master.sv
// Scoreboard bench for dram_bus_master: two instances (WAIT_CYCLES 0 and 2)
// share the clock and reset; index 0 has no wait states, index 1 has two.
module tb_dram_bus_master;

  typedef struct packed {
    logic       rw;
    logic [3:0] addr;
    logic [7:0] data;
  } bus_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } rsp_t;

  logic       clk;
  logic       rstn;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic       req_rw;
  logic [3:0] req_addr;
  logic [1:0] req_len;
  logic [1:0] wdata_valid;
  logic [1:0] wdata_ready;
  logic [7:0] wdata;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_data [2];
  logic [1:0] rsp_last;
  logic [1:0] busy;
  logic [1:0] csn;
  logic [1:0] bus_rw;
  logic [3:0] bus_addr [2];
  logic [7:0] bus_wdata [2];
  logic [1:0] oe;
  logic [7:0] bus_rdata [2];

  int n_vec = 0;
  int n_err = 0;

  bus_t bus_q [2][$];
  int   run_q [2][$];
  rsp_t rsp_q [2][$];
  int   run_len [2];

  // Memory model seen on the bus read path.
  function automatic logic [7:0] rd_model(input logic [3:0] a);
    if (a == 4'h3) return 8'hA5;
    return {~a, a};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bus_rdata[g] = rd_model(bus_addr[g]);
    dram_bus_master #(
      .DWIDTH(8), .AWIDTH(4), .LWIDTH(2), .WAIT_CYCLES(g * 2)
    ) u_dut (
      .i_ck         (clk),
      .i_rstn       (rstn),
      .i_req_valid  (req_valid[g]),
      .o_req_ready  (req_ready[g]),
      .i_req_rw     (req_rw),
      .i_req_addr   (req_addr),
      .i_req_len    (req_len),
      .i_wdata_valid(wdata_valid[g]),
      .o_wdata_ready(wdata_ready[g]),
      .i_wdata      (wdata),
      .o_rsp_valid  (rsp_valid[g]),
      .o_rsp_data   (rsp_data[g]),
      .o_rsp_last   (rsp_last[g]),
      .o_busy       (busy[g]),
      .o_csn        (csn[g]),
      .o_rw         (bus_rw[g]),
      .o_address    (bus_addr[g]),
      .o_data       (bus_wdata[g]),
      .o_data_oe    (oe[g]),
      .i_data       (bus_rdata[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every bus cycle, response pulse and csn-low run is checked
  // against what the stimulus pushed when it issued the request.
  initial begin
    bus_t e;
    rsp_t r;
    run_len[0] = 0;
    run_len[1] = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        run_len[0] = 0;
        run_len[1] = 0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (!csn[d]) begin
            run_len[d]++;
            check($sformatf("d%0d_bus_cycle_expected", d), bus_q[d].size() != 0, 1);
            if (bus_q[d].size() != 0) begin
              e = bus_q[d].pop_front();
              check($sformatf("d%0d_bus_rw", d), bus_rw[d], e.rw);
              check($sformatf("d%0d_bus_addr", d), bus_addr[d], e.addr);
              check($sformatf("d%0d_bus_oe", d), oe[d], !e.rw);
              if (!e.rw) check($sformatf("d%0d_bus_wdata", d), bus_wdata[d], e.data);
            end
          end else begin
            check($sformatf("d%0d_oe_idle", d), oe[d], 0);
            if (run_len[d] > 0) begin
              check($sformatf("d%0d_run_expected", d), run_q[d].size() != 0, 1);
              if (run_q[d].size() != 0)
                check($sformatf("d%0d_csn_run_len", d), run_len[d], run_q[d].pop_front());
            end
            run_len[d] = 0;
          end
          if (rsp_valid[d]) begin
            check($sformatf("d%0d_rsp_expected", d), rsp_q[d].size() != 0, 1);
            if (rsp_q[d].size() != 0) begin
              r = rsp_q[d].pop_front();
              check($sformatf("d%0d_rsp_data", d), rsp_data[d], r.data);
              check($sformatf("d%0d_rsp_last", d), rsp_last[d], r.last);
            end
          end
        end
      end
    end
  end

  // Issue one request; expectations for the whole transfer are queued first.
  task automatic do_req(input int d, input logic rw, input logic [3:0] a, input logic [1:0] len,
                        input logic [31:0] wds, input int stall_beat, input int stall_cyc);
    int         w;
    int         t;
    logic [3:0] ad;
    w  = (d == 0) ? 0 : 2;
    ad = a;
    if (rw) run_q[d].push_back((int'(len) + 1) * (w + 1));
    for (int b = 0; b <= int'(len); b++) begin
      for (int c = 0; c <= w; c++) bus_q[d].push_back('{rw: rw, addr: ad, data: wds[8*b +: 8]});
      if (!rw) run_q[d].push_back(w + 1);
      else     rsp_q[d].push_back('{data: rd_model(ad), last: (b == int'(len))});
      ad = ad + 4'd1;
    end
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_rw       = rw;
    req_addr     = a;
    req_len      = len;
    t = 0;
    while (!req_ready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_accept_timeout", t < 50, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_rw       = ~rw;
    req_addr     = ~a;
    req_len      = ~len;
    if (!rw) begin
      for (int b = 0; b <= int'(len); b++) begin
        if (b == stall_beat) begin
          repeat (stall_cyc) @(negedge clk);
          check("wload_hold_ready", wdata_ready[d], 1);
          check("wload_hold_csn", csn[d], 1);
        end
        wdata_valid[d] = 1'b1;
        wdata          = wds[8*b +: 8];
        t = 0;
        while (!wdata_ready[d] && t < 50) begin
          @(negedge clk);
          t++;
        end
        check("wdata_accept_timeout", t < 50, 1);
        @(posedge clk);
        @(negedge clk);
        wdata_valid[d] = 1'b0;
        wdata          = 8'h00;
      end
    end
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while (busy[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", t < 200, 1);
    @(negedge clk);
  endtask

  initial begin
    rstn        = 1'b1;
    req_valid   = 2'b00;
    req_rw      = 1'b1;
    req_addr    = 4'h0;
    req_len     = 2'd0;
    wdata_valid = 2'b00;
    wdata       = 8'h00;
    #1 rstn = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      check("rst_csn", csn[d], 1);
      check("rst_rw", bus_rw[d], 1);
      check("rst_addr", bus_addr[d], 0);
      check("rst_data", bus_wdata[d], 0);
      check("rst_oe", oe[d], 0);
      check("rst_req_ready", req_ready[d], 0);
      check("rst_wdata_ready", wdata_ready[d], 0);
      check("rst_rsp_valid", rsp_valid[d], 0);
      check("rst_rsp_data", rsp_data[d], 0);
      check("rst_rsp_last", rsp_last[d], 0);
      check("rst_busy", busy[d], 0);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", req_ready[0], 1);

    // Single read, no wait states.
    do_req(0, 1'b1, 4'h3, 2'd0, 32'h0, -1, 0);
    wait_idle(0);

    // Single write with two wait states; bus returns to idle levels afterwards.
    do_req(1, 1'b0, 4'h7, 2'd0, 32'h0000_005C, -1, 0);
    wait_idle(1);
    check("post_write_oe", oe[1], 0);
    check("post_write_rw", bus_rw[1], 1);
    check("post_write_csn", csn[1], 1);

    // Four-beat read wrapping past the top address.
    do_req(0, 1'b1, 4'hE, 2'd3, 32'h0, -1, 0);
    wait_idle(0);

    // Two-beat write with the second word withheld for 5 cycles.
    do_req(0, 1'b0, 4'h4, 2'd1, 32'h0000_2211, 1, 5);
    wait_idle(0);

    // Two-beat read with wait states, wrapping.
    do_req(1, 1'b1, 4'hF, 2'd1, 32'h0, -1, 0);
    wait_idle(1);

    // Back-to-back read then write on the wait-state instance.
    do_req(1, 1'b1, 4'h2, 2'd0, 32'h0, -1, 0);
    check("b2b_ready_low", req_ready[1], 0);
    check("b2b_busy", busy[1], 1);
    do_req(1, 1'b0, 4'h9, 2'd0, 32'h0000_0077, -1, 0);
    wait_idle(1);

    // Reset during beat 2 of a four-beat read.
    do_req(0, 1'b1, 4'h8, 2'd3, 32'h0, -1, 0);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midrst_csn", csn[0], 1);
    check("midrst_oe", oe[0], 0);
    check("midrst_rsp_valid", rsp_valid[0], 0);
    check("midrst_busy", busy[0], 0);
    for (int d = 0; d < 2; d++) begin
      bus_q[d].delete();
      run_q[d].delete();
      rsp_q[d].delete();
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_wdata_ready", wdata_ready[0], 0);
    end
    do_req(0, 1'b1, 4'hA, 2'd1, 32'h0, -1, 0);
    wait_idle(0);

    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("bus_q_drained", bus_q[d].size(), 0);
      check("run_q_drained", run_q[d].size(), 0);
      check("rsp_q_drained", rsp_q[d].size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
